// File: rtl/sha1_msg_wr_sched.sv
// SHA-1 message write scheduler.
// Accepts message blocks as beats, allocates a free message slot per message,
// and turns each beat into one registered write {slot, block index} towards
// the message RAM/core. Slots are returned through the release port.
module sha1_msg_wr_sched #(
    parameter int CHANNEL_NUM_TOTAL = 64,
    parameter int CHANNEL_NUM_WIDTH = $clog2(CHANNEL_NUM_TOTAL),
    parameter int TAG_DATA_WIDTH    = 14,
    parameter int MSG_DATA_WIDTH    = 512,
    parameter int MSG_LEN_WIDTH     = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic                         s_sop,
    input  logic                         s_eop,
    input  logic [MSG_LEN_WIDTH-1:0]     s_len,
    input  logic [TAG_DATA_WIDTH-1:0]    s_tag,
    input  logic [MSG_DATA_WIDTH-1:0]    s_data,
    output logic                         msg_wr_ena,
    output logic                         msg_wr_sop,
    output logic [11:0]                  msg_wr_addr,
    output logic [MSG_LEN_WIDTH-1:0]     msg_wr_len,
    output logic [TAG_DATA_WIDTH-1:0]    msg_wr_tag,
    output logic [MSG_DATA_WIDTH-1:0]    msg_wr_data,
    input  logic                         rel_valid,
    input  logic [CHANNEL_NUM_WIDTH-1:0] rel_slot,
    output logic [CHANNEL_NUM_WIDTH:0]   free_cnt,
    output logic                         seq_err,
    output logic                         rel_err
);

    typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

    // Number of set bits in the free bitmap.
    function automatic logic [CHANNEL_NUM_WIDTH:0] popcount(
        input logic [CHANNEL_NUM_TOTAL-1:0] v
    );
        logic [CHANNEL_NUM_WIDTH:0] c;
        c = '0;
        for (int i = 0; i < CHANNEL_NUM_TOTAL; i++) begin
            c = c + {{CHANNEL_NUM_WIDTH{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Index of the lowest free slot (0 when none is free; callers gate on free_cnt).
    function automatic logic [CHANNEL_NUM_WIDTH-1:0] lowest_free(
        input logic [CHANNEL_NUM_TOTAL-1:0] v
    );
        logic [CHANNEL_NUM_WIDTH-1:0] s;
        s = '0;
        for (int i = CHANNEL_NUM_TOTAL - 1; i >= 0; i--) begin
            if (v[i]) s = CHANNEL_NUM_WIDTH'(i);
        end
        return s;
    endfunction

    state_t                       state_q, state_d;
    logic [CHANNEL_NUM_TOTAL-1:0] free_q, free_d;
    logic [CHANNEL_NUM_WIDTH:0]   free_cnt_q, free_cnt_d;
    logic [CHANNEL_NUM_WIDTH-1:0] slot_q, slot_d;
    logic [MSG_LEN_WIDTH-1:0]     idx_q, idx_d;
    logic [MSG_LEN_WIDTH-1:0]     len_q, len_d;
    logic [TAG_DATA_WIDTH-1:0]    tag_q, tag_d;
    logic                         wr_ena_q, wr_ena_d;
    logic                         wr_sop_q, wr_sop_d;
    logic [11:0]                  wr_addr_q, wr_addr_d;
    logic [MSG_DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
    logic                         seq_err_q, seq_err_d;
    logic                         rel_err_q, rel_err_d;
    logic [CHANNEL_NUM_WIDTH-1:0] alloc_slot;
    logic                         accept;
    logic                         last_blk;

    // Ready comes from registered state only: WRITE always accepts, IDLE needs a free slot.
    assign s_ready = (state_q == WRITE) || (free_cnt_q != '0);
    assign accept  = s_valid && s_ready;

    assign msg_wr_ena  = wr_ena_q;
    assign msg_wr_sop  = wr_sop_q;
    assign msg_wr_addr = wr_addr_q;
    assign msg_wr_len  = len_q;
    assign msg_wr_tag  = tag_q;
    assign msg_wr_data = wr_data_q;
    assign free_cnt    = free_cnt_q;
    assign seq_err     = seq_err_q;
    assign rel_err     = rel_err_q;

    // Next-state: beat handling, slot allocation from the pre-release bitmap, then release.
    always_comb begin
        state_d    = state_q;
        free_d     = free_q;
        slot_d     = slot_q;
        idx_d      = idx_q;
        len_d      = len_q;
        tag_d      = tag_q;
        wr_ena_d   = 1'b0;
        wr_sop_d   = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        seq_err_d  = 1'b0;
        rel_err_d  = 1'b0;
        alloc_slot = lowest_free(free_q);
        last_blk   = (idx_q == len_q);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (s_sop) begin
                        free_d[alloc_slot] = 1'b0;
                        slot_d    = alloc_slot;
                        len_d     = s_len;
                        tag_d     = s_tag;
                        wr_ena_d  = 1'b1;
                        wr_sop_d  = 1'b1;
                        wr_addr_d = {6'(alloc_slot), 6'd0};
                        wr_data_d = s_data;
                        if (s_len == '0) begin
                            // Single-block message: complete on this beat.
                            if (!s_eop) seq_err_d = 1'b1;
                        end else begin
                            idx_d   = MSG_LEN_WIDTH'(1);
                            state_d = WRITE;
                            if (s_eop) seq_err_d = 1'b1;
                        end
                    end else begin
                        // Stray continuation beat with no open message: drop it.
                        seq_err_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (accept) begin
                    wr_ena_d  = 1'b1;
                    wr_addr_d = {6'(slot_q), 6'(idx_q)};
                    wr_data_d = s_data;
                    // The block count alone ends the message; framing flags only flag errors.
                    if (s_sop || (s_eop != last_blk)) seq_err_d = 1'b1;
                    if (last_blk) state_d = IDLE;
                    else          idx_d   = idx_q + MSG_LEN_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (rel_valid) begin
            if ((32'(rel_slot) >= CHANNEL_NUM_TOTAL) || free_q[rel_slot]) rel_err_d = 1'b1;
            else free_d[rel_slot] = 1'b1;
        end

        free_cnt_d = popcount(free_d);
    end

    // State and output registers; reset frees every slot and clears all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            free_q     <= '1;
            free_cnt_q <= (CHANNEL_NUM_WIDTH+1)'(CHANNEL_NUM_TOTAL);
            slot_q     <= '0;
            idx_q      <= '0;
            len_q      <= '0;
            tag_q      <= '0;
            wr_ena_q   <= 1'b0;
            wr_sop_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            seq_err_q  <= 1'b0;
            rel_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            free_q     <= free_d;
            free_cnt_q <= free_cnt_d;
            slot_q     <= slot_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            tag_q      <= tag_d;
            wr_ena_q   <= wr_ena_d;
            wr_sop_q   <= wr_sop_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            seq_err_q  <= seq_err_d;
            rel_err_q  <= rel_err_d;
        end
    end

endmodule

// File: tb/tb_sha1_msg_wr_sched.sv
// Bench for sha1_msg_wr_sched: directed scenarios with a write scoreboard.
module tb_sha1_msg_wr_sched;

    localparam int CNT = 64;
    localparam int CW  = 6;
    localparam int TW  = 14;
    localparam int DW  = 512;
    localparam int LW  = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          s_sop = 1'b0;
    logic          s_eop = 1'b0;
    logic [LW-1:0] s_len = '0;
    logic [TW-1:0] s_tag = '0;
    logic [DW-1:0] s_data = '0;
    logic          msg_wr_ena;
    logic          msg_wr_sop;
    logic [11:0]   msg_wr_addr;
    logic [LW-1:0] msg_wr_len;
    logic [TW-1:0] msg_wr_tag;
    logic [DW-1:0] msg_wr_data;
    logic          rel_valid = 1'b0;
    logic [CW-1:0] rel_slot = '0;
    logic [CW:0]   free_cnt;
    logic          seq_err;
    logic          rel_err;

    sha1_msg_wr_sched #(
        .CHANNEL_NUM_TOTAL(CNT),
        .CHANNEL_NUM_WIDTH(CW),
        .TAG_DATA_WIDTH(TW),
        .MSG_DATA_WIDTH(DW),
        .MSG_LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_sop(s_sop), .s_eop(s_eop),
        .s_len(s_len), .s_tag(s_tag), .s_data(s_data),
        .msg_wr_ena(msg_wr_ena), .msg_wr_sop(msg_wr_sop), .msg_wr_addr(msg_wr_addr),
        .msg_wr_len(msg_wr_len), .msg_wr_tag(msg_wr_tag), .msg_wr_data(msg_wr_data),
        .rel_valid(rel_valid), .rel_slot(rel_slot),
        .free_cnt(free_cnt), .seq_err(seq_err), .rel_err(rel_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0]   addr;
        logic          sop;
        logic [LW-1:0] len;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        int            cyc;
    } wr_t;

    wr_t sb[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  seq_cnt = 0;
    int  rel_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every write must match the oldest expected write, in the expected cycle.
    always @(negedge clk) begin
        if (msg_wr_ena) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h sop=%0b cyc=%0d required=none", msg_wr_addr, msg_wr_sop, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (msg_wr_addr !== mon_e.addr || msg_wr_sop !== mon_e.sop || msg_wr_len !== mon_e.len ||
                    msg_wr_tag !== mon_e.tag || msg_wr_data !== mon_e.data || cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL write got addr=%h sop=%0b len=%0d tag=%h cyc=%0d data_ok=%0b required addr=%h sop=%0b len=%0d tag=%h cyc=%0d",
                             msg_wr_addr, msg_wr_sop, msg_wr_len, msg_wr_tag, cyc, (msg_wr_data === mon_e.data),
                             mon_e.addr, mon_e.sop, mon_e.len, mon_e.tag, mon_e.cyc);
                end
            end
        end
        if (seq_err) seq_cnt++;
        if (rel_err) rel_cnt++;
    end

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one beat (held until accepted); push the expected write if one should result.
    task automatic beat(input logic sop, input logic eop, input logic [LW-1:0] len,
                        input logic [TW-1:0] tag, input logic [CW-1:0] slot,
                        input logic [LW-1:0] idx, input bit exp_wr);
        wr_t e;
        int  waited;
        s_valid = 1'b1; s_sop = sop; s_eop = eop; s_len = len; s_tag = tag;
        s_data  = rand_data();
        waited  = 0;
        while (!s_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!s_ready) begin
            checks++; errors++;
            $display("FAIL beat_ready_timeout s_ready=%0b required=1", s_ready);
            s_valid = 1'b0;
            return;
        end
        if (exp_wr) begin
            e.addr = {slot, idx};
            e.sop  = (idx == '0);
            e.len  = len;
            e.tag  = tag;
            e.data = s_data;
            e.cyc  = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
    endtask

    task automatic msg(input logic [LW-1:0] len, input logic [TW-1:0] tag, input logic [CW-1:0] slot);
        for (int i = 0; i <= int'(len); i++)
            beat(i == 0, i == int'(len), len, tag, slot, LW'(i), 1'b1);
    endtask

    task automatic release_slot(input logic [CW-1:0] s);
        rel_valid = 1'b1; rel_slot = s;
        @(posedge clk); #1;
        rel_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        idle(3);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_pending_writes got=%0d required=0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(2);
        checks++;
        if ({msg_wr_ena, msg_wr_sop, msg_wr_addr, msg_wr_len, msg_wr_tag, seq_err, rel_err} !== '0 || msg_wr_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs ena=%0b sop=%0b addr=%h len=%0d tag=%h required all 0",
                     msg_wr_ena, msg_wr_sop, msg_wr_addr, msg_wr_len, msg_wr_tag);
        end
        checks++;
        if (free_cnt !== 7'd64) begin errors++; $display("FAIL reset_free_cnt got=%0d required=64", free_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%0b required=1", s_ready); end
    endtask

    task automatic test_single();
        int s0 = seq_cnt;
        msg(6'd0, 14'h155, 6'd0);
        drain("single");
        checks++;
        if (free_cnt !== 7'd63) begin errors++; $display("FAIL single_free_cnt got=%0d required=63", free_cnt); end
        checks++;
        if (seq_cnt != s0) begin errors++; $display("FAIL single_seq_err got=%0d required=%0d", seq_cnt, s0); end
    endtask

    task automatic test_back_to_back();
        msg(6'd2, 14'h02A, 6'd1);
        drain("b2b");
        checks++;
        if (free_cnt !== 7'd62) begin errors++; $display("FAIL b2b_free_cnt got=%0d required=62", free_cnt); end
    endtask

    task automatic test_fill();
        for (int s = 2; s < CNT; s++) msg(6'd0, TW'(s), CW'(s));
        drain("fill");
        checks++;
        if (free_cnt !== 7'd0) begin errors++; $display("FAIL fill_free_cnt got=%0d required=0", free_cnt); end
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got=%0b required=0", s_ready); end
        release_slot(6'd5);
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_after_rel got=%0b required=1", s_ready); end
        checks++;
        if (free_cnt !== 7'd1) begin errors++; $display("FAIL fill_free_after_rel got=%0d required=1", free_cnt); end
        msg(6'd0, 14'h0003, 6'd5);
        drain("refill");
        checks++;
        if (free_cnt !== 7'd0) begin errors++; $display("FAIL refill_free_cnt got=%0d required=0", free_cnt); end
    endtask

    task automatic test_rel_err();
        int r0 = rel_cnt;
        release_slot(6'd7);
        idle(2);
        checks++;
        if (rel_cnt != r0) begin errors++; $display("FAIL rel_valid_no_err got=%0d required=%0d", rel_cnt, r0); end
        release_slot(6'd7);
        idle(2);
        checks++;
        if (rel_cnt != r0 + 1) begin errors++; $display("FAIL rel_err_pulse got=%0d required=%0d", rel_cnt, r0 + 1); end
        checks++;
        if (free_cnt !== 7'd1) begin errors++; $display("FAIL rel_err_free_cnt got=%0d required=1", free_cnt); end
    endtask

    task automatic test_same_cycle();
        int r0;
        release_slot(6'd3);
        checks++;
        if (free_cnt !== 7'd2) begin errors++; $display("FAIL same_pre_free_cnt got=%0d required=2", free_cnt); end
        r0 = rel_cnt;
        rel_valid = 1'b1; rel_slot = 6'd2;
        beat(1'b1, 1'b1, 6'd0, 14'h1AB, 6'd3, 6'd0, 1'b1);
        rel_valid = 1'b0;
        drain("same");
        checks++;
        if (free_cnt !== 7'd2) begin errors++; $display("FAIL same_free_cnt got=%0d required=2", free_cnt); end
        checks++;
        if (rel_cnt != r0) begin errors++; $display("FAIL same_rel_err got=%0d required=%0d", rel_cnt, r0); end
    endtask

    task automatic test_seq_err();
        int s0 = seq_cnt;
        beat(1'b0, 1'b1, 6'd0, 14'h0, 6'd0, 6'd0, 1'b0);
        drain("stray");
        checks++;
        if (seq_cnt != s0 + 1) begin errors++; $display("FAIL stray_seq_err got=%0d required=%0d", seq_cnt, s0 + 1); end
        // Early eop on block 0, sop repeated on block 1: both written, count ends the message.
        beat(1'b1, 1'b1, 6'd1, 14'h077, 6'd2, 6'd0, 1'b1);
        beat(1'b1, 1'b1, 6'd1, 14'h077, 6'd2, 6'd1, 1'b1);
        beat(1'b1, 1'b1, 6'd0, 14'h011, 6'd7, 6'd0, 1'b1);
        drain("framing");
        checks++;
        if (seq_cnt != s0 + 3) begin errors++; $display("FAIL framing_seq_err got=%0d required=%0d", seq_cnt, s0 + 3); end
        checks++;
        if (free_cnt !== 7'd0) begin errors++; $display("FAIL framing_free_cnt got=%0d required=0", free_cnt); end
    endtask

    task automatic test_len63();
        apply_reset();
        msg(6'd63, 14'h3FFF, 6'd0);
        drain("len63");
        checks++;
        if (free_cnt !== 7'd63) begin errors++; $display("FAIL len63_free_cnt got=%0d required=63", free_cnt); end
    endtask

    task automatic test_reset_mid();
        beat(1'b1, 1'b0, 6'd5, 14'h1234, 6'd1, 6'd0, 1'b1);
        beat(1'b0, 1'b0, 6'd5, 14'h1234, 6'd1, 6'd1, 1'b1);
        @(negedge clk); #1;
        rst_n = 1'b0;
        s_valid = 1'b1; s_sop = 1'b0; s_eop = 1'b0; s_data = rand_data();
        idle(3);
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got=%0b required=1", s_ready); end
        drain("mid_reset");
        checks++;
        if (free_cnt !== 7'd64) begin errors++; $display("FAIL mid_reset_free_cnt got=%0d required=64", free_cnt); end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_rel_err();
        test_same_cycle();
        test_seq_err();
        test_len63();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha1_msg_wr_sched.md
SHA1_MSG_WR_SCHED -- requirements
Module: sha1_msg_wr_sched

Interface
REQ-001 The block SHALL have parameters: CHANNEL_NUM_TOTAL, 64, number of message slots in the block RAM; CHANNEL_NUM_WIDTH, $clog2(CHANNEL_NUM_TOTAL), slot index width; TAG_DATA_WIDTH, 14, tag width; MSG_DATA_WIDTH, 512, block width; MSG_LEN_WIDTH, 6, block-count field width.
REQ-002 The block SHALL have ports (one clock; reset asynchronous, active-low):
- clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input block beat valid
- s_ready  out  1  beat accepted when s_valid && s_ready
- s_sop  in  1  first block of a message
- s_eop  in  1  last block of a message
- s_len  in  MSG_LEN_WIDTH  block count minus 1; sampled on the sop beat
- s_tag  in  TAG_DATA_WIDTH  message tag; sampled on the sop beat
- s_data  in  MSG_DATA_WIDTH  block payload
- msg_wr_ena  out  1  RAM/core write strobe
- msg_wr_sop  out  1  first block of a message
- msg_wr_addr  out  12  {slot[5:0], block index[5:0]}
- msg_wr_len  out  MSG_LEN_WIDTH  latched s_len
- msg_wr_tag  out  TAG_DATA_WIDTH  latched s_tag
- msg_wr_data  out  MSG_DATA_WIDTH  registered s_data
- rel_valid  in  1  slot release from the core result path
- rel_slot  in  CHANNEL_NUM_WIDTH  slot being released
- free_cnt  out  CHANNEL_NUM_WIDTH+1  number of free slots
- seq_err  out  1  one-cycle pulse on a protocol error
- rel_err  out  1  one-cycle pulse on an invalid release

Function
REQ-003 The block SHALL hold a CHANNEL_NUM_TOTAL-bit free bitmap, where 1 means the slot is free.
REQ-004 The FSM SHALL have two states, IDLE and WRITE.
REQ-005 In IDLE, s_ready SHALL be 1 iff free_cnt != 0.
REQ-006 In WRITE, s_ready SHALL be 1.
REQ-007 An accepted sop beat in IDLE SHALL:
- allocate the lowest-index free slot and clear its bitmap bit;
- latch s_len and s_tag;
- set the block index to 0;
- enter WRITE, unless s_len == 0, in which case the FSM stays in IDLE.
REQ-008 An accepted non-sop beat in IDLE SHALL be discarded: no write, seq_err pulses.
REQ-009 Every accepted beat belonging to a message SHALL produce exactly one msg_wr_ena pulse on the next cycle.
- The pulse SHALL carry msg_wr_addr = {slot, block index} and registered s_data.
- msg_wr_len and msg_wr_tag SHALL carry the latched values.
- Latency SHALL be 1 cycle, with no bubbles.
REQ-010 msg_wr_sop SHALL be 1 only on the write of block index 0.
REQ-011 The block index SHALL increment per accepted beat; when it equals the latched len, the message SHALL end and the FSM SHALL return to IDLE.
REQ-012 The block index SHALL never wrap: len 63 yields indices 0..63.
REQ-013 If s_eop disagrees with the count-based end, or s_sop is 1 on a beat in WRITE, seq_err SHALL pulse. The beat SHALL still be written, and the count alone SHALL determine the message end.
REQ-014 rel_valid SHALL set bitmap[rel_slot] on the next cycle.
REQ-015 Releasing a slot that is already free SHALL leave the state unchanged and pulse rel_err.
REQ-016 Releasing the slot currently being written SHALL count as a valid release.
REQ-017 A simultaneous release and allocation in one cycle SHALL allocate from the pre-release bitmap; free_cnt SHALL net to an unchanged value.
REQ-018 free_cnt SHALL equal the popcount of the bitmap, registered, and SHALL satisfy 0 <= free_cnt <= CHANNEL_NUM_TOTAL.
REQ-019 When the bitmap is empty in IDLE, s_ready SHALL be 0. The first beat after a release SHALL be acceptable on the cycle after rel_valid.
REQ-020 s_ready SHALL depend only on registered state, with no combinational path from s_valid.

Reset
REQ-021 While rst_n is 0, the block SHALL be reset asynchronously:
- FSM = IDLE;
- bitmap = all ones;
- free_cnt = CHANNEL_NUM_TOTAL;
- every other output = 0.
REQ-022 Reset asserted mid-message SHALL abort the message with no further writes; all slots SHALL become free.
REQ-023 Deassertion SHALL take effect on the next clk edge; s_ready SHALL be 1 on the first cycle after reset release.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset, then a single-beat message (sop+eop, len 0, tag 0x155): one write with addr 0x000, sop 1, len 0, tag 0x155; free_cnt 64->63.
- Three-block message (len 2) after that: slot 1 used; addr 0x040, 0x041, 0x042; sop only on the first write; back-to-back with 1-cycle latency.
- Allocate all 64 slots: free_cnt 0, s_ready 0. Then rel_slot 5: s_ready 1 next cycle, and the next message writes addr 0x140.
- Release of an already-free slot 7: rel_err pulses once; free_cnt unchanged.
- Same-cycle release of slot 2 with a sop (lowest free slot 3): slot 3 allocated; free_cnt unchanged.
- Non-sop beat in IDLE: seq_err pulses, no msg_wr_ena. Separately, rst_n asserted after block 1 of a len-5 message: writes stop; free_cnt 64.
